// File: rtl/imm_gen_pipe.sv
// Immediate generator for the miniRISC decode path.
// The control unit selects an extension mode. The extended word and an
// error flag for reserved modes are then pushed into a 2-entry valid/ready
// buffer, so the decode stage can stall without losing immediates.
module imm_gen_pipe #(
  parameter int DATA_W       = 32,
  parameter int IMM_W        = 16,
  parameter int SHAMT_W      = 5,
  parameter int OFFSET_SHIFT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        mode,
  input  logic [IMM_W-1:0]  imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  // Reject parameter sets where the field or the shifted offset cannot fit
  generate
    if (DATA_W < IMM_W + OFFSET_SHIFT) begin : g_bad_data_w
      $error("imm_gen_pipe: DATA_W must be >= IMM_W + OFFSET_SHIFT");
    end
    if (SHAMT_W > IMM_W) begin : g_bad_shamt_w
      $error("imm_gen_pipe: SHAMT_W must be <= IMM_W");
    end
    if (OFFSET_SHIFT < 0 || OFFSET_SHIFT > 3) begin : g_bad_shift
      $error("imm_gen_pipe: OFFSET_SHIFT must be 0..3");
    end
  endgenerate

  logic [DATA_W-1:0] sext;
  logic [DATA_W-1:0] ext_data;
  logic              ext_err;

  logic [DATA_W-1:0] mem_data [2];
  logic              mem_err  [2];
  logic [1:0]        count;
  logic              wr_ptr;
  logic              rd_ptr;
  logic              push;
  logic              pop;

  // Extend the raw field according to the selected mode.
  // Modes 5..7 are reserved: they give data 0 with the error flag set.
  always_comb begin
    sext                 = {DATA_W{imm[IMM_W-1]}};
    sext[IMM_W-1:0]      = imm;
    ext_data             = '0;
    ext_err              = 1'b0;
    case (mode)
      3'd0: ext_data = sext;
      3'd1: ext_data[IMM_W-1:0] = imm;
      3'd2: ext_data[SHAMT_W-1:0] = imm[IMM_W-1 -: SHAMT_W];
      3'd3: ext_data[DATA_W-1 -: IMM_W] = imm;
      3'd4: ext_data = sext << OFFSET_SHIFT;
      default: ext_err = 1'b1;
    endcase
  end

  // Handshakes use only registered state, so in_ready has no path from out_ready
  always_comb begin
    in_ready  = (count != 2'd2);
    out_valid = (count != 2'd0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    out_data  = out_valid ? mem_data[rd_ptr] : '0;
    out_err   = out_valid ? mem_err[rd_ptr]  : 1'b0;
  end

  // Buffer state. Reset and flush clear everything and ignore that cycle's handshakes.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count       <= 2'd0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      mem_data[0] <= '0;
      mem_data[1] <= '0;
      mem_err[0]  <= 1'b0;
      mem_err[1]  <= 1'b0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= ext_data;
        mem_err[wr_ptr]  <= ext_err;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe with hand-computed expected values.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  mode;
  logic [15:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;

  int checks = 0;
  int errors = 0;

  imm_gen_pipe #(.DATA_W(32), .IMM_W(16), .SHAMT_W(5), .OFFSET_SHIFT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling or driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] exp_data, input logic exp_err);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_data"}, out_data, exp_data);
    chk({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_data"}, out_data, 32'd0);
    chk({tag, "_err"}, {31'd0, out_err}, 32'd0);
  endtask

  task automatic offer(input logic [2:0] m, input logic [15:0] v);
    in_valid = 1'b1;
    mode     = m;
    imm      = v;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mode = 3'd0; imm = 16'h0;
    tick(); tick();
    rst = 1'b0;
    chk_empty("reset");

    // Mode sweep: each result is at the head exactly one edge after its push
    out_ready = 1'b1;
    offer(3'd0, 16'h8001); tick(); chk_head("m0", 32'hFFFF8001, 1'b0);
    offer(3'd1, 16'h8001); tick(); chk_head("m1", 32'h00008001, 1'b0);
    offer(3'd2, 16'hF800); tick(); chk_head("m2", 32'h0000001F, 1'b0);
    offer(3'd3, 16'h1234); tick(); chk_head("m3", 32'h12340000, 1'b0);
    offer(3'd4, 16'hFFFF); tick(); chk_head("m4", 32'hFFFFFFFC, 1'b0);
    offer(3'd4, 16'h0001); tick(); chk_head("m4pos", 32'h00000004, 1'b0);
    in_valid = 1'b0; tick();
    chk("sweep_drain", {31'd0, out_valid}, 32'd0);

    // Backpressure: the buffer fills after two pushes and holds the third offer
    out_ready = 1'b0;
    offer(3'd1, 16'h0001); tick();
    chk("bp1_ready", {31'd0, in_ready}, 32'd1);
    chk("bp1_data", out_data, 32'h1);
    offer(3'd1, 16'h0002); tick();
    chk("bp2_ready", {31'd0, in_ready}, 32'd0);
    chk("bp2_data", out_data, 32'h1);
    offer(3'd1, 16'h0003); tick();
    chk("bp3_ready", {31'd0, in_ready}, 32'd0);
    chk("bp3_hold", out_data, 32'h1);
    out_ready = 1'b1; tick();
    chk("bp_pop1_data", out_data, 32'h2);
    chk("bp_pop1_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_pop2_data", out_data, 32'h3);
    in_valid = 1'b0; tick();
    chk("bp_drain", {31'd0, out_valid}, 32'd0);

    // Push and pop together with one entry buffered: order is kept and count stays 1
    out_ready = 1'b0;
    offer(3'd0, 16'h7FFF); tick(); chk_head("pp0", 32'h00007FFF, 1'b0);
    out_ready = 1'b1;
    offer(3'd0, 16'h8000); tick(); chk_head("pp1", 32'hFFFF8000, 1'b0);
    chk("pp1_ready", {31'd0, in_ready}, 32'd1);
    offer(3'd0, 16'h0000); tick(); chk_head("pp2", 32'h00000000, 1'b0);
    chk("pp2_ready", {31'd0, in_ready}, 32'd1);
    offer(3'd0, 16'hFFFF); tick(); chk_head("pp3", 32'hFFFFFFFF, 1'b0);
    in_valid = 1'b0; tick();
    chk("pp_drain", {31'd0, out_valid}, 32'd0);

    // Reserved mode gives data 0 with err set; the next legal entry clears err
    out_ready = 1'b0;
    offer(3'd6, 16'hABCD); tick(); chk_head("rsv", 32'h0, 1'b1);
    out_ready = 1'b1;
    offer(3'd1, 16'h0042); tick(); chk_head("rsv_next", 32'h00000042, 1'b0);
    in_valid = 1'b0; tick();

    // Flush with a full buffer while an offer is present
    out_ready = 1'b0;
    offer(3'd1, 16'h00AA); tick();
    offer(3'd1, 16'h00BB); tick();
    chk("fl_full", {31'd0, in_ready}, 32'd0);
    flush = 1'b1; out_ready = 1'b1; offer(3'd1, 16'h00CC); tick();
    flush = 1'b0; in_valid = 1'b0;
    chk_empty("flush_full");
    tick();
    chk("flush_full_after", {31'd0, out_valid}, 32'd0);

    // Flush with one entry while a push is accepted by in_ready: the push is dropped
    out_ready = 1'b0;
    offer(3'd1, 16'h00DD); tick();
    flush = 1'b1; offer(3'd1, 16'h00EE); tick();
    flush = 1'b0; in_valid = 1'b0;
    chk_empty("flush_one");
    tick();
    chk("flush_one_after", {31'd0, out_valid}, 32'd0);

    // Reset mid-stream drops the entry and the same-cycle push
    offer(3'd1, 16'h0055); tick();
    rst = 1'b1; offer(3'd1, 16'h0066); tick();
    rst = 1'b0; in_valid = 1'b0;
    chk_empty("rst_mid");
    tick();
    chk("rst_mid_after", {31'd0, out_valid}, 32'd0);
    offer(3'd3, 16'h1234); tick(); chk_head("post_rst", 32'h12340000, 1'b0);
    in_valid = 1'b0; out_ready = 1'b1; tick();
    chk("post_rst_drain", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
